sfm_sched: RTL and testbench
============================

# sfm_sched

Two-pass softmax scheduler that sequences the softmax datapath and its streamer for one vector job. Pass 1 streams the input so the datapath accumulates max and exponent sum. Pass 2 re-streams the input and writes the normalized result back. The block sits between the register-file controller and the datapath/streamer pair. It issues streamer load requests, drives the datapath operation code, and generates the last-beat lane mask for vector lengths that are not a multiple of the lane count.

## Interface
- DATA_WIDTH, 128, stream beat width in bits
- ELEM_WIDTH, 16, element width in bits; LANES = DATA_WIDTH/ELEM_WIDTH (localparam, 8 by default)
- LEN_WIDTH, 32, width of the element-count field
- ADDR_WIDTH, 32, byte address width
- clk_i  in  1  single clock
- rst_i  in  1  reset, asynchronous, active-high
- clear_i  in  1  synchronous soft clear
- start_i  in  1  job start pulse
- len_i  in  LEN_WIDTH  vector length in elements
- in_addr_i, out_addr_i  in  ADDR_WIDTH  source and destination base addresses
- rd_req_o  out  1  read-stream load request
- rd_addr_o  out  ADDR_WIDTH  read base address
- rd_beats_o  out  LEN_WIDTH  number of beats to read
- rd_ack_i  in  1  streamer accepted the read request
- wr_req_o  out  1  write-stream load request
- wr_addr_o  out  ADDR_WIDTH  write base address
- wr_beats_o  out  LEN_WIDTH  number of beats to write
- wr_ack_i  in  1  streamer accepted the write request
- wr_done_i  in  1  write stream completed, one-cycle pulse
- in_beat_i  in  1  input beat handshake (valid & ready)
- dp_acc_done_i  in  1  datapath reduction complete
- dp_op_o  out  2  datapath op: 0 idle, 1 accumulate, 2 normalize
- dp_last_o  out  1  current input beat is the last of the pass
- strb_o  out  LANES  lane mask for the current input beat
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle completion pulse

## Operation
- BEATS = ceil(len/LANES); REM = len mod LANES. Both are latched at start, together with the two addresses.
- The lane mask is all ones, except on the last beat when REM≠0; that beat's mask is (1<<REM)-1.
- States: IDLE, ACC_REQ, ACC, ACC_WAIT, NORM_REQ, NORM, NORM_WAIT, DONE.
- IDLE: start_i with len_i≠0 goes to ACC_REQ. start_i with len_i=0 goes directly to DONE and issues no requests.
- ACC_REQ: rd_req_o=1. On rd_ack_i, go to ACC.
- ACC: dp_op_o=1. The beat counter increments on in_beat_i. On in_beat_i at count BEATS-1, go to ACC_WAIT.
- ACC_WAIT: dp_op_o=1. On dp_acc_done_i, go to NORM_REQ.
- NORM_REQ: rd_req_o=1 and wr_req_o=1. Each request drops independently on its own ack. Once both are acked (same or different cycles), go to NORM.
- NORM: dp_op_o=2. The counter restarts at 0 and counts as in ACC. On the last beat, go to NORM_WAIT.
- NORM_WAIT: dp_op_o=2. Exits to DONE once wr_done_i has been seen.
- wr_done_i is latched sticky from entry to NORM_REQ onward. An early write-done therefore still counts.
- DONE: done_o=1 for one cycle, then IDLE.
- start_i outside IDLE is ignored.
- clear_i in any state returns the block to IDLE, zeroes the counter and sticky flag, and emits no done_o. clear_i has priority over start_i.
- rd_addr_o/rd_beats_o/wr_addr_o/wr_beats_o hold their latched values for the whole job. The address outputs are in_addr_i/out_addr_i as latched at start; both beat-count outputs are BEATS.

## Timing
- All outputs are registered or decoded from registered state. No combinational path from any input to any output.
- Reset values: state IDLE, counter 0, all request/op/done/busy/last outputs 0, strb_o all ones, address and beat-count outputs 0.
- busy_o=1 in every state except IDLE, including DONE.
- start_i sampled in cycle T gives rd_req_o=1 in T+1.
- A request is held high until the cycle its ack is sampled, and is low the following cycle.
- dp_last_o and the tail strb_o are valid in the same cycle as the counter value BEATS-1, before and during its in_beat_i.
- When BEATS=1, dp_last_o=1 for the whole ACC and NORM states.
- Counter width is LEN_WIDTH. len = 2^LEN_WIDTH-1 must compute BEATS without overflow.

## Test plan
- len=16, LANES=8: expect rd_req twice, 2 beats per pass, dp_last on the 2nd beat, strb always 0xFF, done_o once, busy low after.
- len=13: BEATS=2. The last-beat strb_o=0x1F in both passes; the first beat is 0xFF.
- len=0: done_o exactly 2 cycles after start_i, no rd_req_o/wr_req_o, dp_op_o stays 0.
- In NORM_REQ, wr_ack_i 3 cycles before rd_ack_i: wr_req_o drops after its ack, and the transition to NORM waits for rd_ack_i. In a second run, wr_done_i pulses during NORM: DONE still follows the last input beat.
- clear_i asserted during ACC with 1 of 4 beats consumed: IDLE next cycle, no done_o. A new start with len=8 then runs correctly from beat 0.
- start_i held high throughout a len=8 job: exactly one job until done_o. A new job starts on the IDLE cycle after DONE. rst_i asserted mid-NORM forces all outputs to their reset values immediately.

Source files
------------

// File: rtl/sfm_sched.sv
// Two-pass softmax scheduler: pass 1 streams input for max/exp-sum accumulation,
// pass 2 re-streams input and writes the normalized result back.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | waiting for start_i
//   ACC_REQ   | read request raised for the accumulation pass
//   ACC       | datapath accumulating, counting input beats
//   ACC_WAIT  | all beats sent, waiting for the datapath reduction
//   NORM_REQ  | read and write requests raised for the normalize pass
//   NORM      | datapath normalizing, counting input beats
//   NORM_WAIT | all beats sent, waiting for the write stream to finish
//   DONE      | job finished, done pulse follows on the next cycle
module sfm_sched #(
  parameter int DATA_WIDTH = 128,
  parameter int ELEM_WIDTH = 16,
  parameter int LEN_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  localparam int LANES     = DATA_WIDTH / ELEM_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [ADDR_WIDTH-1:0] in_addr_i,
  input  logic [ADDR_WIDTH-1:0] out_addr_i,
  output logic                  rd_req_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [LEN_WIDTH-1:0]  rd_beats_o,
  input  logic                  rd_ack_i,
  output logic                  wr_req_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [LEN_WIDTH-1:0]  wr_beats_o,
  input  logic                  wr_ack_i,
  input  logic                  wr_done_i,
  input  logic                  in_beat_i,
  input  logic                  dp_acc_done_i,
  output logic [1:0]            dp_op_o,
  output logic                  dp_last_o,
  output logic [LANES-1:0]      strb_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int LANE_SHIFT = $clog2(LANES);
  localparam logic [LANES-1:0] LANE_ONES = '1;
  localparam logic [1:0] OP_IDLE = 2'd0;
  localparam logic [1:0] OP_ACC  = 2'd1;
  localparam logic [1:0] OP_NORM = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC_REQ,
    S_ACC,
    S_ACC_WAIT,
    S_NORM_REQ,
    S_NORM,
    S_NORM_WAIT,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic [LEN_WIDTH-1:0] beats_q;
  logic [LANES-1:0]     tail_q;
  logic                 wr_done_seen_q;

  logic [LEN_WIDTH-1:0] len_rem;
  logic [LEN_WIDTH-1:0] len_beats;
  logic [LANES-1:0]     len_tail;
  logic [LEN_WIDTH-1:0] cnt_inc;
  logic                 inc_last;
  logic                 first_last;
  logic                 rd_ok;
  logic                 wr_ok;

  // Shift-and-round-up keeps BEATS in range even for an all-ones length.
  always_comb begin
    len_rem   = len_i & LEN_WIDTH'(LANES - 1);
    len_beats = (len_i >> LANE_SHIFT) + {{(LEN_WIDTH-1){1'b0}}, (len_rem != '0)};
    len_tail  = LANE_ONES;
    if (len_rem != '0)
      len_tail = ~(LANE_ONES << len_rem);
  end

  always_comb begin
    cnt_inc    = cnt_q + LEN_WIDTH'(1);
    inc_last   = (cnt_inc == beats_q - LEN_WIDTH'(1));
    first_last = (beats_q == LEN_WIDTH'(1));
    rd_ok      = !rd_req_o || rd_ack_i;
    wr_ok      = !wr_req_o || wr_ack_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      beats_q        <= '0;
      tail_q         <= LANE_ONES;
      wr_done_seen_q <= 1'b0;
      rd_req_o       <= 1'b0;
      wr_req_o       <= 1'b0;
      rd_addr_o      <= '0;
      wr_addr_o      <= '0;
      rd_beats_o     <= '0;
      wr_beats_o     <= '0;
      dp_op_o        <= OP_IDLE;
      dp_last_o      <= 1'b0;
      strb_o         <= LANE_ONES;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else if (clear_i) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      wr_done_seen_q <= 1'b0;
      rd_req_o       <= 1'b0;
      wr_req_o       <= 1'b0;
      dp_op_o        <= OP_IDLE;
      dp_last_o      <= 1'b0;
      strb_o         <= LANE_ONES;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (wr_done_i && (state_q == S_NORM_REQ || state_q == S_NORM || state_q == S_NORM_WAIT))
        wr_done_seen_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            beats_q    <= len_beats;
            tail_q     <= len_tail;
            rd_addr_o  <= in_addr_i;
            wr_addr_o  <= out_addr_i;
            rd_beats_o <= len_beats;
            wr_beats_o <= len_beats;
            busy_o     <= 1'b1;
            cnt_q      <= '0;
            if (len_i == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q  <= S_ACC_REQ;
              rd_req_o <= 1'b1;
            end
          end
        end

        S_ACC_REQ: begin
          if (rd_ack_i) begin
            rd_req_o  <= 1'b0;
            state_q   <= S_ACC;
            dp_op_o   <= OP_ACC;
            cnt_q     <= '0;
            dp_last_o <= first_last;
            strb_o    <= first_last ? tail_q : LANE_ONES;
          end
        end

        S_ACC: begin
          if (in_beat_i) begin
            if (dp_last_o) begin
              state_q   <= S_ACC_WAIT;
              dp_last_o <= 1'b0;
              strb_o    <= LANE_ONES;
            end else begin
              cnt_q     <= cnt_inc;
              dp_last_o <= inc_last;
              strb_o    <= inc_last ? tail_q : LANE_ONES;
            end
          end
        end

        S_ACC_WAIT: begin
          if (dp_acc_done_i) begin
            state_q        <= S_NORM_REQ;
            dp_op_o        <= OP_IDLE;
            rd_req_o       <= 1'b1;
            wr_req_o       <= 1'b1;
            wr_done_seen_q <= 1'b0;
          end
        end

        // Each request drops on its own ack; the pass starts once both have been taken.
        S_NORM_REQ: begin
          if (rd_ack_i)
            rd_req_o <= 1'b0;
          if (wr_ack_i)
            wr_req_o <= 1'b0;
          if (rd_ok && wr_ok) begin
            state_q   <= S_NORM;
            dp_op_o   <= OP_NORM;
            cnt_q     <= '0;
            dp_last_o <= first_last;
            strb_o    <= first_last ? tail_q : LANE_ONES;
          end
        end

        S_NORM: begin
          if (in_beat_i) begin
            if (dp_last_o) begin
              state_q   <= S_NORM_WAIT;
              dp_last_o <= 1'b0;
              strb_o    <= LANE_ONES;
            end else begin
              cnt_q     <= cnt_inc;
              dp_last_o <= inc_last;
              strb_o    <= inc_last ? tail_q : LANE_ONES;
            end
          end
        end

        S_NORM_WAIT: begin
          if (wr_done_seen_q || wr_done_i) begin
            state_q <= S_DONE;
            dp_op_o <= OP_IDLE;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          done_o  <= 1'b1;
          busy_o  <= 1'b0;
          cnt_q   <= '0;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfm_sched.sv
// Directed bench for sfm_sched: full jobs, tail masks, zero length, ack skew,
// early write-done, soft clear, held start and asynchronous reset.
module tb_sfm_sched;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        start;
  logic [31:0] len;
  logic [31:0] in_addr;
  logic [31:0] out_addr;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [31:0] rd_beats;
  logic        rd_ack;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_beats;
  logic        wr_ack;
  logic        wr_done;
  logic        in_beat;
  logic        dp_acc_done;
  logic [1:0]  dp_op;
  logic        dp_last;
  logic [7:0]  strb;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;
  int rd_rise = 0;
  int done_cnt = 0;
  logic rd_prev = 1'b0;

  sfm_sched dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clear_i       (clear),
    .start_i       (start),
    .len_i         (len),
    .in_addr_i     (in_addr),
    .out_addr_i    (out_addr),
    .rd_req_o      (rd_req),
    .rd_addr_o     (rd_addr),
    .rd_beats_o    (rd_beats),
    .rd_ack_i      (rd_ack),
    .wr_req_o      (wr_req),
    .wr_addr_o     (wr_addr),
    .wr_beats_o    (wr_beats),
    .wr_ack_i      (wr_ack),
    .wr_done_i     (wr_done),
    .in_beat_i     (in_beat),
    .dp_acc_done_i (dp_acc_done),
    .dp_op_o       (dp_op),
    .dp_last_o     (dp_last),
    .strb_o        (strb),
    .busy_o        (busy),
    .done_o        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rd_req && !rd_prev) rd_rise++;
    rd_prev = rd_req;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete job; rd_lag = cycles between wr_ack and rd_ack in NORM_REQ.
  task automatic do_job(input int l, input int beats, input logic [7:0] tail,
                        input int rd_lag, input bit early_wd, input bit hold);
    int rise0;
    int done0;
    rise0    = rd_rise;
    done0    = done_cnt;
    start    = 1'b1;
    len      = l;
    in_addr  = 32'h1000_0000 + l;
    out_addr = 32'h2000_0000 + l;
    tick();
    if (!hold) start = 1'b0;
    check("rd_req_after_start", rd_req, 1);
    check("busy_after_start", busy, 1);
    check("rd_beats", rd_beats, beats);
    check("wr_beats", wr_beats, beats);
    check("rd_addr", rd_addr, 32'h1000_0000 + l);
    check("wr_addr", wr_addr, 32'h2000_0000 + l);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("rd_req_dropped", rd_req, 0);
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < beats; b++) begin
        check("dp_op_pass", dp_op, p + 1);
        check("dp_last", dp_last, (b == beats - 1));
        check("strb", strb, (b == beats - 1) ? tail : 8'hFF);
        in_beat = 1'b1;
        if (p == 1 && b == 0 && early_wd) wr_done = 1'b1;
        tick();
        in_beat = 1'b0;
        wr_done = 1'b0;
      end
      check("dp_op_wait", dp_op, p + 1);
      check("dp_last_wait", dp_last, 0);
      if (p == 0) begin
        dp_acc_done = 1'b1;
        tick();
        dp_acc_done = 1'b0;
        check("norm_rd_req", rd_req, 1);
        check("norm_wr_req", wr_req, 1);
        check("dp_op_norm_req", dp_op, 0);
        if (rd_lag == 0) begin
          rd_ack = 1'b1;
          wr_ack = 1'b1;
          tick();
          rd_ack = 1'b0;
          wr_ack = 1'b0;
        end else begin
          wr_ack = 1'b1;
          tick();
          wr_ack = 1'b0;
          for (int k = 1; k < rd_lag; k++) begin
            check("skew_wr_req_low", wr_req, 0);
            check("skew_rd_req_high", rd_req, 1);
            check("skew_still_req", dp_op, 0);
            tick();
          end
          check("skew_wr_req_low", wr_req, 0);
          check("skew_rd_req_high", rd_req, 1);
          rd_ack = 1'b1;
          tick();
          rd_ack = 1'b0;
        end
        check("norm_reqs_low", {rd_req, wr_req}, 2'b00);
      end else begin
        if (!early_wd) wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
      end
    end
    check("done_state_busy", busy, 1);
    check("done_state_pulse_low", done, 0);
    check("done_state_op", dp_op, 0);
    check("job_rd_rises", rd_rise - rise0, 2);
    tick();
    check("done_pulse", done, 1);
    check("busy_after_done", busy, 0);
    tick();
    check("done_one_cycle", done, 0);
    check("job_done_count", done_cnt - done0, 1);
    check("restart_on_held_start", rd_req, hold);
  endtask

  initial begin
    int done0;
    rst = 1'b1;
    clear = 1'b0;
    start = 1'b0;
    len = '0;
    in_addr = '0;
    out_addr = '0;
    rd_ack = 1'b0;
    wr_ack = 1'b0;
    wr_done = 1'b0;
    in_beat = 1'b0;
    dp_acc_done = 1'b0;
    #23 rst = 1'b0;
    tick();

    check("rst_rd_req", rd_req, 0);
    check("rst_wr_req", wr_req, 0);
    check("rst_dp_op", dp_op, 0);
    check("rst_last", dp_last, 0);
    check("rst_strb", strb, 8'hFF);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", {rd_addr, wr_addr}, 64'h0);
    check("rst_beats", {rd_beats, wr_beats}, 64'h0);

    do_job(16, 2, 8'hFF, 0, 1'b0, 1'b0);
    do_job(13, 2, 8'h1F, 0, 1'b0, 1'b0);

    // Zero length: straight to DONE, pulse two cycles after start.
    done0 = done_cnt;
    start = 1'b1;
    len = 0;
    tick();
    start = 1'b0;
    check("len0_no_rd_req", rd_req, 0);
    check("len0_busy", busy, 1);
    check("len0_op", dp_op, 0);
    check("len0_done_not_yet", done, 0);
    tick();
    check("len0_done", done, 1);
    check("len0_no_reqs", {rd_req, wr_req}, 2'b00);
    check("len0_op_idle", dp_op, 0);
    tick();
    check("len0_done_count", done_cnt - done0, 1);

    do_job(16, 2, 8'hFF, 3, 1'b0, 1'b0);
    do_job(24, 3, 8'hFF, 0, 1'b1, 1'b0);
    do_job(5, 1, 8'h1F, 0, 1'b0, 1'b0);
    do_job(9, 2, 8'h01, 1, 1'b0, 1'b0);

    // Soft clear after one of four beats.
    done0 = done_cnt;
    start = 1'b1;
    len = 32;
    tick();
    start = 1'b0;
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    in_beat = 1'b1;
    tick();
    in_beat = 1'b0;
    check("pre_clear_op", dp_op, 1);
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    check("clear_busy", busy, 0);
    check("clear_op", dp_op, 0);
    check("clear_reqs", {rd_req, wr_req}, 2'b00);
    check("clear_strb", strb, 8'hFF);
    tick();
    check("clear_no_done", done_cnt - done0, 0);
    do_job(8, 1, 8'hFF, 0, 1'b0, 1'b0);

    // Maximum length: beat count must not overflow.
    start = 1'b1;
    len = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    check("maxlen_beats", rd_beats, 32'h2000_0000);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("maxlen_cleared", busy, 0);

    // Start held high: one job, then a restart; reset mid-NORM of the second.
    do_job(8, 1, 8'hFF, 0, 1'b0, 1'b1);
    start = 1'b0;
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    in_beat = 1'b1;
    tick();
    in_beat = 1'b0;
    dp_acc_done = 1'b1;
    tick();
    dp_acc_done = 1'b0;
    rd_ack = 1'b1;
    wr_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    wr_ack = 1'b0;
    check("second_job_norm", dp_op, 2);
    rst = 1'b1;
    #1;
    check("arst_op", dp_op, 0);
    check("arst_busy", busy, 0);
    check("arst_last", dp_last, 0);
    check("arst_strb", strb, 8'hFF);
    check("arst_addr", {rd_addr, wr_addr}, 64'h0);
    check("arst_beats", rd_beats, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_idle", {busy, done, rd_req}, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
